wiegand_frame_buf: RTL and testbench

WIEGAND_FRAME_BUF -- requirements
Module: wiegand_frame_buf

---
 rtl/wiegand_frame_buf_if.sv | 34 +++
 rtl/wiegand_frame_buf.sv | 160 ++++++++++++++++
 tb/tb_wiegand_frame_buf.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wiegand_frame_buf_if.sv
// Host-side bundle for the Wiegand frame buffer: receiver frame strobe,
// local-bus address/data/strobes, read data and interrupt.
interface wiegand_frame_buf_if;
  logic        frame_valid;
  logic [25:0] frame;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic        nOE;
  logic        nWE;
  logic [7:0]  rdata;
  logic        IRQ;

  modport master (
    output frame_valid,
    output frame,
    output addr,
    output wdata,
    output nOE,
    output nWE,
    input  rdata,
    input  IRQ
  );

  modport slave (
    input  frame_valid,
    input  frame,
    input  addr,
    input  wdata,
    input  nOE,
    input  nWE,
    output rdata,
    output IRQ
  );
endinterface

// File: rtl/wiegand_frame_buf.sv
// Wiegand-26 frame FIFO with parity check and 8-bit local-bus registers.
// Ports: clk, nCPLDCE (async active-low reset), bus (frame in, regs, IRQ).
module wiegand_frame_buf #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              nCPLDCE,
  wiegand_frame_buf_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [25:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          enable;
  logic          ovf;
  logic          perr;
  logic          irq_q;

  logic oe_s1, oe_s2, oe_d;
  logic we_s1, we_s2, we_d;

  logic oe_end, we_end;
  logic full, empty;
  logic good;
  logic fv_en;
  logic ctrl_wr;
  logic flush;
  logic pop;
  logic push;
  logic ovf_set, perr_set;

  logic [CW-1:0] count_n;
  logic          enable_n;
  logic          ovf_n;
  logic          perr_n;

  logic [25:0] head;
  logic [3:0]  cnt_wide;
  logic [2:0]  cnt_rep;
  logic [7:0]  status;
  logic        ctrl_unused;

  // Strobe ends are rising edges of the synchronized strobes.
  assign oe_end = oe_s2 & ~oe_d;
  assign we_end = we_s2 & ~we_d;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Upper half: bit 25 makes 25..13 even; lower half: bit 0 makes 12..0 odd.
  assign good = ~(^bus.frame[25:13]) & (^bus.frame[12:0]);

  assign fv_en   = bus.frame_valid & enable;
  assign ctrl_wr = we_end & (bus.addr == 3'd0);
  assign flush   = ctrl_wr & bus.wdata[0];
  assign pop     = oe_end & (bus.addr == 3'd4) & ~empty;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = fv_en & good & (~full | pop) & ~flush;
  assign ovf_set  = fv_en & good & full & ~pop & ~flush;
  assign perr_set = fv_en & ~good & ~flush;

  assign ctrl_unused = ^{bus.wdata[6:4], bus.wdata[1]};

  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_n = count + CW'(1);
        2'b01:   count_n = count - CW'(1);
        default: count_n = count;
      endcase
    end
  end

  // Set takes priority over a clear arriving in the same cycle.
  always_comb begin
    enable_n = enable;
    ovf_n    = ovf;
    perr_n   = perr;
    if (ctrl_wr) begin
      enable_n = bus.wdata[7];
      if (bus.wdata[2]) ovf_n  = 1'b0;
      if (bus.wdata[3]) perr_n = 1'b0;
    end
    if (ovf_set)  ovf_n  = 1'b1;
    if (perr_set) perr_n = 1'b1;
  end

  always_ff @(posedge clk or negedge nCPLDCE) begin
    if (!nCPLDCE) begin
      oe_s1  <= 1'b1;
      oe_s2  <= 1'b1;
      oe_d   <= 1'b1;
      we_s1  <= 1'b1;
      we_s2  <= 1'b1;
      we_d   <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      enable <= 1'b1;
      ovf    <= 1'b0;
      perr   <= 1'b0;
      irq_q  <= 1'b1;
    end else begin
      oe_s1 <= bus.nOE;
      oe_s2 <= oe_s1;
      oe_d  <= oe_s2;
      we_s1 <= bus.nWE;
      we_s2 <= we_s1;
      we_d  <= we_s2;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      count  <= count_n;
      enable <= enable_n;
      ovf    <= ovf_n;
      perr   <= perr_n;
      // Built from next-state values so IRQ moves with STATUS.
      irq_q  <= ~(enable_n &
                  ((count_n != '0) | ovf_n | perr_n));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.frame;
  end

  assign head = empty ? 26'd0 : mem[rd_ptr];

  assign cnt_wide = 4'(count);
  assign cnt_rep  = (cnt_wide > 4'd7) ? 3'd7 : cnt_wide[2:0];
  assign status   = {enable, cnt_rep, perr, ovf, full, ~empty};

  always_comb begin
    bus.rdata = 8'h00;
    case (bus.addr)
      3'd0:    bus.rdata = status;
      3'd1:    bus.rdata = head[7:0];
      3'd2:    bus.rdata = head[15:8];
      3'd3:    bus.rdata = head[23:16];
      3'd4:    bus.rdata = {6'b0, head[25:24]};
      3'd5:    bus.rdata = head[24:17];
      default: bus.rdata = 8'h00;
    endcase
  end

  assign bus.IRQ = irq_q;

endmodule

// File: tb/tb_wiegand_frame_buf.sv
// Directed bench for wiegand_frame_buf (DEPTH=4).
// Drives on negedge, samples after negedge; immediate assertions.
`timescale 1ns/1ps
module tb_wiegand_frame_buf;

  logic clk;
  logic nCPLDCE;
  int   total;
  int   bad;

  wiegand_frame_buf_if ifc ();

  wiegand_frame_buf #(.DEPTH(4)) dut (
    .clk     (clk),
    .nCPLDCE (nCPLDCE),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  initial begin
    #20ms;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] mkframe(input logic [23:0] d);
    logic [25:0] f;
    f       = {1'b0, d, 1'b0};
    f[25]   = ^f[24:13];
    f[0]    = ~(^f[12:1]);
    return f;
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [2:0] a,
                      output logic [7:0] rd);
    ifc.addr = a;
    #1;
    rd = ifc.rdata;
  endtask

  task automatic pulse(input logic [25:0] f);
    @(negedge clk);
    ifc.frame_valid = 1'b1;
    ifc.frame = f;
    @(negedge clk);
    ifc.frame_valid = 1'b0;
  endtask

  // Bus strobe; optional frame_valid aligned with the strobe-end cycle.
  task automatic bus_cycle(input bit wr,
                           input logic [2:0] a,
                           input logic [7:0] d,
                           input bit fv,
                           input logic [25:0] f,
                           output logic [7:0] rd);
    @(negedge clk);
    ifc.addr = a;
    ifc.wdata = d;
    if (wr) ifc.nWE = 1'b0;
    else    ifc.nOE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd = ifc.rdata;
    if (wr) ifc.nWE = 1'b1;
    else    ifc.nOE = 1'b1;
    @(negedge clk);
    @(negedge clk);
    if (fv) begin
      ifc.frame_valid = 1'b1;
      ifc.frame = f;
    end
    @(negedge clk);
    ifc.frame_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_ctrl(input logic [7:0] d);
    logic [7:0] rd;
    bus_cycle(1'b1, 3'd0, d, 1'b0, 26'd0, rd);
  endtask

  task automatic chk_status(input string tag,
                            input logic [7:0] exp);
    logic [7:0] rd;
    peek(3'd0, rd);
    chk(tag, rd, exp);
  endtask

  task automatic chk_irq(input string tag,
                         input logic exp);
    chk(tag, {7'b0, ifc.IRQ}, {7'b0, exp});
  endtask

  task automatic chk_pop(input string tag,
                         input logic [25:0] f);
    logic [7:0] rd;
    logic [25:0] v;
    v = f;
    peek(3'd1, rd); chk({tag, "_b0"}, rd, v[7:0]);
    peek(3'd2, rd); chk({tag, "_b1"}, rd, v[15:8]);
    peek(3'd3, rd); chk({tag, "_b2"}, rd, v[23:16]);
    bus_cycle(1'b0, 3'd4, 8'h00, 1'b0, 26'd0, rd);
    chk({tag, "_b3"}, rd, {6'b0, v[25:24]});
  endtask

  logic [25:0] fr [6];
  logic [7:0]  rd;
  logic [25:0] g;

  initial begin
    total = 0;
    bad = 0;
    nCPLDCE = 1'b0;
    ifc.frame_valid = 1'b0;
    ifc.frame = '0;
    ifc.addr = '0;
    ifc.wdata = '0;
    ifc.nOE = 1'b1;
    ifc.nWE = 1'b1;
    fr[0] = mkframe(24'h0A1B2C);
    fr[1] = mkframe(24'h3C4D5E);
    fr[2] = mkframe(24'hF01234);
    fr[3] = mkframe(24'h55AA33);
    fr[4] = mkframe(24'h800001);
    fr[5] = mkframe(24'h7E7E7E);

    repeat (3) @(negedge clk);
    nCPLDCE = 1'b1;
    repeat (3) @(negedge clk);
    chk_status("rst_status", 8'h80);
    chk_irq("rst_irq", 1'b1);
    peek(3'd1, rd); chk("rst_head", rd, 8'h00);

    pulse(26'h2B42469);
    chk_status("good_status", 8'h91);
    chk_irq("good_irq", 1'b0);
    peek(3'd1, rd); chk("good_a1", rd, 8'h69);
    peek(3'd2, rd); chk("good_a2", rd, 8'h24);
    peek(3'd3, rd); chk("good_a3", rd, 8'hB4);
    peek(3'd4, rd); chk("good_a4", rd, 8'h02);
    peek(3'd5, rd); chk("good_a5", rd, 8'h5A);
    peek(3'd6, rd); chk("good_a6", rd, 8'h00);
    peek(3'd7, rd); chk("good_a7", rd, 8'h00);
    bus_cycle(1'b0, 3'd4, 8'h00, 1'b0, 26'd0, rd);
    chk("pop_data", rd, 8'h02);
    chk_status("pop_status", 8'h80);
    chk_irq("pop_irq", 1'b1);

    pulse(26'h2B42468);
    chk_status("perr_status", 8'h88);
    chk_irq("perr_irq", 1'b0);
    wr_ctrl(8'h88);
    chk_status("perr_clr", 8'h80);
    chk_irq("perr_clr_irq", 1'b1);

    for (int i = 0; i < 5; i++) pulse(fr[i]);
    chk_status("ovf_status", 8'hC7);
    wr_ctrl(8'h84);
    chk_status("ovf_clr", 8'hC3);

    peek(3'd1, rd); chk("f0_b0", rd, fr[0][7:0]);
    peek(3'd2, rd); chk("f0_b1", rd, fr[0][15:8]);
    peek(3'd3, rd); chk("f0_b2", rd, fr[0][23:16]);
    bus_cycle(1'b0, 3'd4, 8'h00, 1'b1, fr[5], rd);
    chk("f0_b3", rd, {6'b0, fr[0][25:24]});
    chk_status("pushpop_status", 8'hC3);
    chk_pop("f1", fr[1]);
    chk_pop("f2", fr[2]);
    chk_pop("f3", fr[3]);
    chk_pop("f5", fr[5]);
    chk_status("drain_status", 8'h80);
    chk_irq("drain_irq", 1'b1);

    bus_cycle(1'b0, 3'd4, 8'h00, 1'b0, 26'd0, rd);
    chk("empty_pop", rd, 8'h00);
    chk_status("empty_pop_status", 8'h80);

    wr_ctrl(8'h00);
    chk_status("dis_status", 8'h00);
    pulse(fr[0]);
    chk_status("dis_good", 8'h00);
    chk_irq("dis_irq", 1'b1);
    pulse(26'h2B42468);
    chk_status("dis_bad", 8'h00);
    wr_ctrl(8'h80);
    chk_status("en_status", 8'h80);
    pulse(fr[1]);
    pulse(fr[2]);
    chk_status("two_status", 8'hA1);
    chk_irq("two_irq", 1'b0);
    wr_ctrl(8'h81);
    chk_status("flush_status", 8'h80);
    chk_irq("flush_irq", 1'b1);

    bus_cycle(1'b1, 3'd0, 8'h88, 1'b1, 26'h2B42468, rd);
    chk_status("set_wins", 8'h88);
    bus_cycle(1'b1, 3'd0, 8'h81, 1'b1, fr[3], rd);
    chk_status("flush_wins", 8'h88);
    wr_ctrl(8'h88);
    chk_status("clr_again", 8'h80);

    pulse(fr[0]);
    pulse(fr[1]);
    pulse(fr[2]);
    chk_status("three_status", 8'hB1);
    @(negedge clk);
    ifc.addr = 3'd0;
    ifc.nOE = 1'b0;
    repeat (3) @(negedge clk);
    nCPLDCE = 1'b0;
    #1;
    chk("arst_status", ifc.rdata, 8'h80);
    chk_irq("arst_irq", 1'b1);
    ifc.addr = 3'd4;
    repeat (2) @(negedge clk);
    nCPLDCE = 1'b1;
    repeat (3) @(negedge clk);
    ifc.nOE = 1'b1;
    repeat (4) @(negedge clk);
    chk_status("post_rst", 8'h80);
    g = fr[4];
    pulse(g);
    chk_status("post_rst_push", 8'h91);
    peek(3'd1, rd); chk("post_rst_head", rd, g[7:0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
